load_align_ext: RTL and testbench
=================================

// Module: load_align_ext
// PURPOSE
//  Multi-cycle load data path between the LSU address stage and the data-memory port. Accepts one load
//  request (byte address + sx_op), issues one or two word-aligned memory reads, merges them for accesses
//  that cross a word boundary, then byte-aligns and sign/zero-extends the result to DATA_WIDTH.
//  Replaces the combinational load-extension path; adds misaligned split handling, backpressure and 64-bit ops.
// PARAMETERS
//  DATA_WIDTH  32  datapath/memory word width in bits; legal values 32 or 64
//  ADDR_WIDTH  32  byte-address width
// PORTS
//  clk            in   1              clock, rising edge
//  rst            in   1              asynchronous, active-high reset
//  req_valid      in   1              load request valid
//  req_ready      out  1              high only in IDLE; request accepted on req_valid&&req_ready
//  req_addr       in   ADDR_WIDTH     byte address of the load
//  req_sx_op      in   4              sx_op_t from isa_shared (size + signedness)
//  mem_req_valid  out  1              memory read request valid
//  mem_req_ready  in   1              memory accepts request
//  mem_req_addr   out  ADDR_WIDTH     word-aligned read address; low log2(DATA_WIDTH/8) bits always 0
//  mem_rsp_valid  in   1              read data valid; exactly one per accepted mem request, in order
//  mem_rsp_data   in   DATA_WIDTH     read word, little-endian
//  rsp_valid      out  1              load result valid; held until rsp_ready
//  rsp_ready      in   1              consumer accepts result
//  rsp_data       out  DATA_WIDTH     aligned, extended load result
//  rsp_err        out  1              illegal op for this DATA_WIDTH; qualified by rsp_valid
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; mem_req_valid=0, mem_req_addr=0; rsp_valid=0, rsp_data=0, rsp_err=0.
//  - Legal ops: SX_0700, SXU_0700, SX_1500, SXU_1500, SX_3100 (all widths); SXU_3100, SX_6300 only at DATA_WIDTH=64.
//    Any other code, including SX_1100 and SX_2000 (immediate formats), is illegal.
//  - FSM: IDLE -> REQ0 -> WAIT0 -> [REQ1 -> WAIT1] -> DONE -> IDLE.
//    IDLE: on accept, register addr/op. Legal op -> REQ0. Illegal op -> DONE with rsp_err=1, rsp_data=0;
//      no memory access is made.
//    REQ0: mem_req_valid=1, mem_req_addr=aligned(addr); advance on mem_req_ready.
//    WAIT0: on mem_rsp_valid capture lo word. If off+nbytes > DATA_WIDTH/8 -> REQ1; else -> DONE.
//      off = addr[log2(DATA_WIDTH/8)-1:0]; nbytes = 1/2/4/8.
//    REQ1: mem_req_addr = aligned(addr)+DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH); advance on mem_req_ready.
//    WAIT1: on mem_rsp_valid capture hi word -> DONE.
//    DONE: rsp_valid=1, rsp_data/rsp_err stable; on rsp_ready -> IDLE.
//  - Result: {hi,lo} (hi=0 if unsplit) >> (off*8); take low nbytes*8 bits; sign-extend from the top bit for SX_*,
//    zero-extend for SXU_*; SX_6300 passes through. Result is registered when entering DONE.
//  - Latency with zero memory wait: aligned load, accept cycle T -> rsp_valid at T+3;
//    split load -> T+5; illegal op -> T+1.
//  - req_ready=0 in every state but IDLE; no new request is taken in the cycle DONE hands off (IDLE next cycle).
//  - mem_rsp_valid outside WAIT0/WAIT1 is ignored and does not alter state.
//  - mem_req_valid/addr held stable until mem_req_ready (no retraction).
//  - rst mid-operation returns to IDLE immediately; in-flight memory responses arriving later are ignored.
// STRUCTURE
//  - isa_shared: sx_op_t widened to 4 bits; SX_*/SXU_* encodings plus new SXU_3100, SX_6300; typedef ld_state_t.
//  - Sub-module: signext_v2 (combinational: {hi,lo}, off, op -> extended data), reusable by the immediate path.
// TESTING  (DATA_WIDTH=32 unless noted)
//  - SX_0700 @0x1003, word 0x80123456 -> one mem req @0x1000, rsp_data=0xFFFFFF80, rsp_err=0.
//  - SXU_1500 @0x2002, word 0xBEEF0000 -> rsp_data=0x0000BEEF.
//  - SX_3100 @0x1002, words 0xAABBCCDD @0x1000 / 0x11223344 @0x1004 -> reqs 0x1000, 0x1004; rsp_data=0x3344AABB.
//  - Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid, rsp_data stable, req_ready=0; one handoff only.
//  - rst in WAIT1, then a late mem_rsp_valid -> outputs at reset values, FSM stays IDLE.
//  - SX_2000, and SX_6300 at DW=32 -> rsp_err=1 at T+1, no mem_req_valid;
//    DW=64: SXU_3100 @0x4, word 0x80000000_xxxxxxxx -> 0x00000000_80000000.

Source files
------------

// File: rtl/load_align_ext_pkg.sv
// Shared types and helpers for the load align/extend data path.
package load_align_ext_pkg;

  // Load size/signedness selector; codes 7 and 8 are immediate formats
  // and are never legal as a load.
  typedef enum logic [3:0] {
    SX_0700  = 4'd0,
    SXU_0700 = 4'd1,
    SX_1500  = 4'd2,
    SXU_1500 = 4'd3,
    SX_3100  = 4'd4,
    SXU_3100 = 4'd5,
    SX_6300  = 4'd6,
    SX_1100  = 4'd7,
    SX_2000  = 4'd8
  } sx_op_t;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_REQ0  = 3'd1,
    LD_WAIT0 = 3'd2,
    LD_REQ1  = 3'd3,
    LD_WAIT1 = 3'd4,
    LD_DONE  = 3'd5
  } ld_state_t;

  // A load op is legal if its size fits the datapath width.
  function automatic logic op_legal(input sx_op_t op, input int dw);
    logic ok;
    case (op)
      SX_0700, SXU_0700, SX_1500, SXU_1500, SX_3100: ok = 1'b1;
      SXU_3100, SX_6300:                             ok = (dw == 64);
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Number of bytes read by a load op (0 for non-load codes).
  function automatic logic [3:0] op_nbytes(input sx_op_t op);
    logic [3:0] n;
    case (op)
      SX_0700, SXU_0700: n = 4'd1;
      SX_1500, SXU_1500: n = 4'd2;
      SX_3100, SXU_3100: n = 4'd4;
      SX_6300:           n = 4'd8;
      default:           n = 4'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_align_ext_if.sv
// Request, memory and response handshakes of the load align/extend block.
interface load_align_ext_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [3:0]            req_sx_op;
  logic                  mem_req_valid;
  logic                  mem_req_ready;
  logic [ADDR_WIDTH-1:0] mem_req_addr;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_addr, req_sx_op, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
    output req_ready, mem_req_valid, mem_req_addr, rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_sx_op, mem_req_ready, mem_rsp_valid, mem_rsp_data, rsp_ready,
    input  req_ready, mem_req_valid, mem_req_addr, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/load_align_ext_signext.sv
// Combinational byte-align and sign/zero-extend of a two-word window.
module signext_v2
  import load_align_ext_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [OFF_W-1:0]      off,
  input  sx_op_t                op,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;

  assign shifted = DATA_WIDTH'({hi, lo} >> {off, 3'b000});

  // Keep the low bytes of the shifted window and extend to full width.
  always_comb begin
    data = '0;
    case (op)
      SX_0700:  data = DATA_WIDTH'($signed(shifted[7:0]));
      SXU_0700: data = DATA_WIDTH'(shifted[7:0]);
      SX_1500:  data = DATA_WIDTH'($signed(shifted[15:0]));
      SXU_1500: data = DATA_WIDTH'(shifted[15:0]);
      SX_3100:  data = DATA_WIDTH'($signed(shifted[31:0]));
      SXU_3100: data = DATA_WIDTH'(shifted[31:0]);
      SX_6300:  data = shifted;
      default:  data = '0;
    endcase
  end

endmodule

// File: rtl/load_align_ext.sv
// Multi-cycle load path: word reads, split merge, align and extend.
module load_align_ext
  import load_align_ext_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input logic             clk,
  input logic             rst,
  load_align_ext_if.slave bus
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);

  ld_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  sx_op_t                op_q, op_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic [OFF_W-1:0]      off;
  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic [4:0]            span;
  logic                  split;
  logic                  req_legal;
  logic [DATA_WIDTH-1:0] ext_hi, ext_lo, ext_data;

  assign off          = addr_q[OFF_W-1:0];
  assign aligned_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign span         = 5'(off) + 5'(op_nbytes(op_q));
  assign split        = span > 5'(BYTES);
  assign req_legal    = op_legal(sx_op_t'(bus.req_sx_op), DATA_WIDTH);

  // Feed the extender straight from the memory bus in the capture cycle.
  assign ext_lo = (state_q == LD_WAIT1) ? lo_q : bus.mem_rsp_data;
  assign ext_hi = (state_q == LD_WAIT1) ? bus.mem_rsp_data : '0;

  signext_v2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF_W      (OFF_W)
  ) u_signext (
    .hi   (ext_hi),
    .lo   (ext_lo),
    .off  (off),
    .op   (op_q),
    .data (ext_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LD_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic walking the one- or two-read sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:  if (bus.req_valid) state_d = req_legal ? LD_REQ0 : LD_DONE;
      LD_REQ0:  if (bus.mem_req_ready) state_d = LD_WAIT0;
      LD_WAIT0: if (bus.mem_rsp_valid) state_d = split ? LD_REQ1 : LD_DONE;
      LD_REQ1:  if (bus.mem_req_ready) state_d = LD_WAIT1;
      LD_WAIT1: if (bus.mem_rsp_valid) state_d = LD_DONE;
      LD_DONE:  if (bus.rsp_ready) state_d = LD_IDLE;
      default:  state_d = LD_IDLE;
    endcase
  end

  // Datapath updates: capture request, low word, and the final result.
  always_comb begin
    addr_d = addr_q;
    op_d   = op_q;
    lo_d   = lo_q;
    data_d = data_q;
    err_d  = err_q;
    case (state_q)
      LD_IDLE: if (bus.req_valid) begin
        addr_d = bus.req_addr;
        op_d   = sx_op_t'(bus.req_sx_op);
        data_d = '0;
        err_d  = !req_legal;
      end
      LD_WAIT0: if (bus.mem_rsp_valid) begin
        lo_d = bus.mem_rsp_data;
        if (!split) data_d = ext_data;
      end
      LD_WAIT1: if (bus.mem_rsp_valid) data_d = ext_data;
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      op_q   <= SX_0700;
      lo_q   <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      op_q   <= op_d;
      lo_q   <= lo_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.req_ready     = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_addr  = '0;
    bus.rsp_valid     = 1'b0;
    bus.rsp_data      = data_q;
    bus.rsp_err       = err_q;
    case (state_q)
      LD_IDLE: bus.req_ready = 1'b1;
      LD_REQ0: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = aligned_addr;
      end
      LD_REQ1: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = aligned_addr + ADDR_WIDTH'(BYTES);
      end
      LD_DONE: bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_align_ext.sv
// Directed bench for load_align_ext at 32-bit and 64-bit datapath widths.
module tb_load_align_ext;
  import load_align_ext_pkg::*;

  logic clk;
  logic rst;

  load_align_ext_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus32 ();
  load_align_ext_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) bus64 ();

  load_align_ext #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut32 (
    .clk (clk),
    .rst (rst),
    .bus (bus32)
  );

  load_align_ext #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  int checks = 0;
  int errors = 0;

  // Memory contents and response delay, written only by the main sequence.
  logic [31:0] memAddr0, memData0, memAddr1, memData1;
  int          memDelay;

  // Memory-side bookkeeping, written only by the responders.
  logic [31:0] reqLog32 [0:15];
  int          reqCount32 = 0;
  int          reqCount64 = 0;
  logic        pend32 = 1'b0;
  int          cnt32 = 0;
  logic [31:0] pendAddr32 = '0;
  logic        pend64 = 1'b0;
  logic [31:0] pendAddr64 = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem32Read(input logic [31:0] a);
    if (a == memAddr0) return memData0;
    if (a == memAddr1) return memData1;
    return 32'h0;
  endfunction

  function automatic logic [63:0] mem64Read(input logic [31:0] a);
    if (a == 32'h0) return 64'h80000000_12345678;
    if (a == 32'h8) return 64'hDEADBEEF_CAFEF00D;
    return 64'h0;
  endfunction

  // 32-bit memory model: one response per accepted request after memDelay extra cycles.
  always @(negedge clk) begin
    if (pend32 && cnt32 == 0) begin
      bus32.mem_rsp_valid = 1'b1;
      bus32.mem_rsp_data  = mem32Read(pendAddr32);
      pend32 = 1'b0;
    end else begin
      bus32.mem_rsp_valid = 1'b0;
      bus32.mem_rsp_data  = 32'h0;
      if (pend32) cnt32 = cnt32 - 1;
    end
    if (bus32.mem_req_valid && bus32.mem_req_ready) begin
      pend32     = 1'b1;
      cnt32      = memDelay;
      pendAddr32 = bus32.mem_req_addr;
      reqLog32[reqCount32 % 16] = bus32.mem_req_addr;
      reqCount32 = reqCount32 + 1;
    end
  end

  // 64-bit memory model: zero-wait responses.
  always @(negedge clk) begin
    if (pend64) begin
      bus64.mem_rsp_valid = 1'b1;
      bus64.mem_rsp_data  = mem64Read(pendAddr64);
      pend64 = 1'b0;
    end else begin
      bus64.mem_rsp_valid = 1'b0;
      bus64.mem_rsp_data  = 64'h0;
    end
    if (bus64.mem_req_valid && bus64.mem_req_ready) begin
      pend64     = 1'b1;
      pendAddr64 = bus64.mem_req_addr;
      reqCount64 = reqCount64 + 1;
    end
  end

  // Step to just after the next falling edge, after the memory models have run.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one request on the 32-bit DUT and wait (bounded) for rsp_valid.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] op, output int lat);
    tick();
    bus32.req_valid = 1'b1;
    bus32.req_addr  = addr;
    bus32.req_sx_op = op;
    tick();
    bus32.req_valid = 1'b0;
    lat = 1;
    while (!bus32.rsp_valid && lat < 20) begin
      tick();
      lat = lat + 1;
    end
    if (!bus32.rsp_valid) checkOutput("rsp_timeout", 64'(bus32.rsp_valid), 64'd1);
  endtask

  task automatic applyStimulus64(input logic [31:0] addr, input logic [3:0] op, output int lat);
    tick();
    bus64.req_valid = 1'b1;
    bus64.req_addr  = addr;
    bus64.req_sx_op = op;
    tick();
    bus64.req_valid = 1'b0;
    lat = 1;
    while (!bus64.rsp_valid && lat < 20) begin
      tick();
      lat = lat + 1;
    end
    if (!bus64.rsp_valid) checkOutput("rsp64_timeout", 64'(bus64.rsp_valid), 64'd1);
  endtask

  task automatic releaseRsp();
    bus32.rsp_ready = 1'b1;
    tick();
    bus32.rsp_ready = 1'b0;
    checkOutput("handoff_rsp_valid", 64'(bus32.rsp_valid), 64'd0);
    checkOutput("handoff_req_ready", 64'(bus32.req_ready), 64'd1);
  endtask

  task automatic releaseRsp64();
    bus64.rsp_ready = 1'b1;
    tick();
    bus64.rsp_ready = 1'b0;
    checkOutput("handoff64_rsp_valid", 64'(bus64.rsp_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int startCount;
    int waitCycles;
    logic [31:0] heldData;

    rst = 1'b1;
    memDelay = 0;
    memAddr0 = '0; memData0 = '0; memAddr1 = '1; memData1 = '0;
    bus32.req_valid = 1'b0; bus32.req_addr = '0; bus32.req_sx_op = '0;
    bus32.mem_req_ready = 1'b1; bus32.rsp_ready = 1'b0;
    bus64.req_valid = 1'b0; bus64.req_addr = '0; bus64.req_sx_op = '0;
    bus64.mem_req_ready = 1'b1; bus64.rsp_ready = 1'b0;

    tick();
    tick();
    checkOutput("reset_req_ready", 64'(bus32.req_ready), 64'd1);
    checkOutput("reset_mem_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    checkOutput("reset_mem_req_addr", 64'(bus32.mem_req_addr), 64'd0);
    checkOutput("reset_rsp_valid", 64'(bus32.rsp_valid), 64'd0);
    checkOutput("reset_rsp_data", 64'(bus32.rsp_data), 64'd0);
    checkOutput("reset_rsp_err", 64'(bus32.rsp_err), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] signed byte load at 0x1003");
    memAddr0 = 32'h1000; memData0 = 32'h80123456;
    startCount = reqCount32;
    applyStimulus(32'h1003, SX_0700, lat);
    checkOutput("sxb_data", 64'(bus32.rsp_data), 64'hFFFFFF80);
    checkOutput("sxb_err", 64'(bus32.rsp_err), 64'd0);
    checkOutput("sxb_latency", 64'(lat), 64'd3);
    checkOutput("sxb_req_count", 64'(reqCount32 - startCount), 64'd1);
    checkOutput("sxb_req_addr", 64'(reqLog32[startCount % 16]), 64'h1000);
    releaseRsp();

    $display("[TB] unsigned half load at 0x2002");
    memAddr0 = 32'h2000; memData0 = 32'hBEEF0000;
    applyStimulus(32'h2002, SXU_1500, lat);
    checkOutput("sxuh_data", 64'(bus32.rsp_data), 64'h0000BEEF);
    checkOutput("sxuh_latency", 64'(lat), 64'd3);
    releaseRsp();

    $display("[TB] split word load at 0x1002");
    memAddr0 = 32'h1000; memData0 = 32'hAABBCCDD;
    memAddr1 = 32'h1004; memData1 = 32'h11223344;
    startCount = reqCount32;
    applyStimulus(32'h1002, SX_3100, lat);
    checkOutput("split_data", 64'(bus32.rsp_data), 64'h3344AABB);
    checkOutput("split_err", 64'(bus32.rsp_err), 64'd0);
    checkOutput("split_latency", 64'(lat), 64'd5);
    checkOutput("split_req_count", 64'(reqCount32 - startCount), 64'd2);
    checkOutput("split_req0_addr", 64'(reqLog32[startCount % 16]), 64'h1000);
    checkOutput("split_req1_addr", 64'(reqLog32[(startCount + 1) % 16]), 64'h1004);
    releaseRsp();

    $display("[TB] response held under backpressure");
    memAddr0 = 32'h1000; memData0 = 32'h80123456;
    applyStimulus(32'h1001, SX_1500, lat);
    checkOutput("bp_data", 64'(bus32.rsp_data), 64'h00001234);
    heldData = bus32.rsp_data;
    bus32.req_valid = 1'b1;
    bus32.req_addr  = 32'h0;
    bus32.req_sx_op = SX_2000;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("bp_rsp_valid", 64'(bus32.rsp_valid), 64'd1);
      checkOutput("bp_rsp_data", 64'(bus32.rsp_data), 64'(heldData));
      checkOutput("bp_req_ready", 64'(bus32.req_ready), 64'd0);
    end
    releaseRsp();
    bus32.req_valid = 1'b0;
    tick();
    checkOutput("bp_single_handoff", 64'(bus32.rsp_valid), 64'd0);

    $display("[TB] reset while waiting for the second word");
    memDelay = 3;
    memAddr0 = 32'h1000; memData0 = 32'hAABBCCDD;
    memAddr1 = 32'h1004; memData1 = 32'h11223344;
    startCount = reqCount32;
    tick();
    bus32.req_valid = 1'b1;
    bus32.req_addr  = 32'h1002;
    bus32.req_sx_op = SX_3100;
    tick();
    bus32.req_valid = 1'b0;
    waitCycles = 0;
    while (reqCount32 - startCount < 2 && waitCycles < 40) begin
      tick();
      waitCycles = waitCycles + 1;
    end
    checkOutput("rst_second_req_seen", 64'(reqCount32 - startCount), 64'd2);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("rst_async_req_ready", 64'(bus32.req_ready), 64'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("rst_idle_req_ready", 64'(bus32.req_ready), 64'd1);
    checkOutput("rst_mem_req_valid", 64'(bus32.mem_req_valid), 64'd0);
    checkOutput("rst_mem_req_addr", 64'(bus32.mem_req_addr), 64'd0);
    checkOutput("rst_rsp_valid", 64'(bus32.rsp_valid), 64'd0);
    checkOutput("rst_rsp_data", 64'(bus32.rsp_data), 64'd0);
    checkOutput("rst_rsp_err", 64'(bus32.rsp_err), 64'd0);
    memDelay = 0;

    $display("[TB] illegal ops at 32-bit width");
    startCount = reqCount32;
    applyStimulus(32'h1000, SX_2000, lat);
    checkOutput("imm_err", 64'(bus32.rsp_err), 64'd1);
    checkOutput("imm_data", 64'(bus32.rsp_data), 64'd0);
    checkOutput("imm_latency", 64'(lat), 64'd1);
    checkOutput("imm_no_mem", 64'(reqCount32 - startCount), 64'd0);
    releaseRsp();
    applyStimulus(32'h1000, SX_6300, lat);
    checkOutput("dw32_sx6300_err", 64'(bus32.rsp_err), 64'd1);
    checkOutput("dw32_sx6300_data", 64'(bus32.rsp_data), 64'd0);
    checkOutput("dw32_sx6300_latency", 64'(lat), 64'd1);
    checkOutput("dw32_sx6300_no_mem", 64'(reqCount32 - startCount), 64'd0);
    releaseRsp();

    $display("[TB] 64-bit datapath loads");
    startCount = reqCount64;
    applyStimulus64(32'h4, SXU_3100, lat);
    checkOutput("dw64_sxuw_data", bus64.rsp_data, 64'h00000000_80000000);
    checkOutput("dw64_sxuw_err", 64'(bus64.rsp_err), 64'd0);
    checkOutput("dw64_sxuw_latency", 64'(lat), 64'd3);
    checkOutput("dw64_sxuw_req_count", 64'(reqCount64 - startCount), 64'd1);
    releaseRsp64();
    applyStimulus64(32'h8, SX_6300, lat);
    checkOutput("dw64_sxd_data", bus64.rsp_data, 64'hDEADBEEF_CAFEF00D);
    checkOutput("dw64_sxd_err", 64'(bus64.rsp_err), 64'd0);
    releaseRsp64();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
